uart_rx_word: RTL and testbench

Receive-side counterpart of the FFT result link. The block deserialises 8N1 UART bytes from the host-side line and reassembles groups of `BYTES` bytes into one word on `data_out`, most significant byte first. It runs in the 100 MHz `clk` domain and is used for loopback verification of the transmit path and for host-to-FPGA command/config words. It provides start-bit glitch rejection, mid-bit sampling, framing-error detection and an inter-byte timeout that resynchronises word assembly.

---
 rtl/uart_rx_word_if.sv | 14 +
 rtl/uart_rx_word.sv | 159 +++++++++++++++
 tb/tb_uart_rx_word.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_word_if.sv
// Serial line and word-output bundle for uart_rx_word.
// The master side drives rx. The slave side is the receiver, which drives the word outputs.
interface uart_rx_word_if #(
    parameter int unsigned BYTES = 4
);
    logic                 rx;
    logic [8*BYTES-1:0]   data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (output rx, input data_out, input data_valid, input frame_err, input busy);
    modport slave  (input rx, output data_out, output data_valid, output frame_err, output busy);
endinterface

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs BYTES bytes, MSB first, into one output word.
// It rejects start glitches, flags framing errors and discards a partial word after an inter-byte timeout.
module uart_rx_word #(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned BYTES        = 4,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_word_if.slave link
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned TO_MAX       = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TO_W         = $clog2(TO_MAX + 1);
    localparam int unsigned IDX_W        = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned WORD_W       = 8 * BYTES;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_MAX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic               rx_meta, rx_s, rx_d;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         bit_cnt, bit_cnt_n;
    logic [7:0]         shreg, shreg_n;
    logic               start_det, byte_good, byte_bad;

    logic [WORD_W-1:0]  word, word_next, data_out_q;
    logic [IDX_W-1:0]   idx;
    logic [TO_W-1:0]    to_cnt;
    logic               data_valid_q, frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= link.rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        start_det = 1'b0;
        byte_good = 1'b0;
        byte_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_d && !rx_s) begin
                    start_det = 1'b1;
                    cnt_n     = '0;
                    state_n   = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    if (bit_cnt == 3'd7) state_n = STOP;
                    else                 bit_cnt_n = bit_cnt + 3'd1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                // Back to IDLE at mid-stop so an immediately following start edge is seen.
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    state_n   = IDLE;
                    byte_good = rx_s;
                    byte_bad  = !rx_s;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign word_next = (word << 8) | WORD_W'(shreg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word         <= '0;
            idx          <= '0;
            to_cnt       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= byte_bad;
            if (byte_bad) begin
                idx  <= '0;
                word <= '0;
            end else if (byte_good) begin
                word <= word_next;
                if (idx == IDX_LAST) begin
                    idx          <= '0;
                    data_out_q   <= word_next;
                    data_valid_q <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            // Timeout runs only while idle with a partial word pending.
            if (start_det || state != IDLE || idx == '0) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt <= '0;
                idx    <= '0;
                word   <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    assign link.data_out   = data_out_q;
    assign link.data_valid = data_valid_q;
    assign link.frame_err  = frame_err_q;
    assign link.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word, run at a fast baud rate (16 clocks per bit) to keep runs short.
module tb_uart_rx_word;
    localparam int unsigned CLK_FREQ     = 100_000_000;
    localparam int unsigned BAUD         = 6_250_000;
    localparam int unsigned CPB          = 16;
    localparam int unsigned BYTES        = 4;
    localparam int unsigned TIMEOUT_BITS = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_word_if #(.BYTES(BYTES)) link ();

    uart_rx_word #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .BYTES(BYTES),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .link(link)
    );

    int          tests = 0;
    int          fails = 0;
    int unsigned vcnt = 0;
    int unsigned fcnt = 0;
    int unsigned both_cnt = 0;
    logic [31:0] last_word = '0;

    always @(negedge clk) begin
        if (link.data_valid) begin
            vcnt      = vcnt + 1;
            last_word = link.data_out;
        end
        if (link.frame_err) fcnt = fcnt + 1;
        if (link.data_valid && link.frame_err) both_cnt = both_cnt + 1;
    end

    typedef struct {
        logic [31:0] word;
        int unsigned gap;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bits(input int unsigned n);
        link.rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        link.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            link.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        link.rx = stop;
        repeat (CPB) @(negedge clk);
        link.rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8], 1'b1);
            if (gap != 0 && k != 0) idle_bits(gap);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_out"},   link.data_out, 32'h0);
        check({tag, "_data_valid"}, 32'(link.data_valid), 32'h0);
        check({tag, "_frame_err"},  32'(link.frame_err), 32'h0);
        check({tag, "_busy"},       32'(link.busy), 32'h0);
    endtask

    int unsigned v0, f0;

    initial begin
        vecs[0] = '{word: 32'h12345678, gap: 0};
        vecs[1] = '{word: 32'hFFFFF830, gap: 0};
        vecs[2] = '{word: 32'h00000001, gap: 0};
        vecs[3] = '{word: 32'hABCDEF01, gap: 15};
        vecs[4] = '{word: 32'h7E8118E7, gap: 1};

        rst_n   = 1'b0;
        link.rx = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int unsigned i = 0; i < 5; i++) begin
            v0 = vcnt;
            f0 = fcnt;
            send_word(vecs[i].word, vecs[i].gap);
            check($sformatf("vec%0d_valid_count", i), 32'(vcnt - v0), 32'd1);
            check($sformatf("vec%0d_data_out", i), last_word, vecs[i].word);
            check($sformatf("vec%0d_no_frame_err", i), 32'(fcnt - f0), 32'd0);
        end

        // Short low glitch: must not start a byte and must release busy quickly.
        idle_bits(2);
        v0 = vcnt;
        f0 = fcnt;
        link.rx = 1'b0;
        repeat (5) @(negedge clk);
        link.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy_high", 32'(link.busy), 32'd1);
        repeat (4) @(negedge clk);
        check("glitch_busy_dropped", 32'(link.busy), 32'd0);
        idle_bits(2);
        check("glitch_no_valid", 32'(vcnt - v0), 32'd0);
        check("glitch_no_ferr", 32'(fcnt - f0), 32'd0);
        send_word(32'hA5A5A5A5, 0);
        check("glitch_word_valid", 32'(vcnt - v0), 32'd1);
        check("glitch_word_data", last_word, 32'hA5A5A5A5);

        // Bad stop bit after one good byte: flag the error and restart word assembly.
        idle_bits(2);
        v0 = vcnt;
        f0 = fcnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h55, 1'b0);
        idle_bits(1);
        check("ferr_count", 32'(fcnt - f0), 32'd1);
        check("ferr_no_valid", 32'(vcnt - v0), 32'd0);
        send_word(32'hDEADBEEF, 0);
        check("ferr_next_valid", 32'(vcnt - v0), 32'd1);
        check("ferr_next_data", last_word, 32'hDEADBEEF);
        check("ferr_single", 32'(fcnt - f0), 32'd1);

        // Inter-byte timeout: discard a partial word after a long idle gap.
        idle_bits(2);
        v0 = vcnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle_bits(25);
        check("timeout_no_valid", 32'(vcnt - v0), 32'd0);
        send_word(32'hCAFEF00D, 0);
        check("timeout_valid", 32'(vcnt - v0), 32'd1);
        check("timeout_data", last_word, 32'hCAFEF00D);

        // Reset during data bit 3 of the second byte.
        idle_bits(2);
        send_byte(8'h11, 1'b1);
        link.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            link.rx = (i % 2 == 0);
            repeat (CPB) @(negedge clk);
        end
        link.rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n   = 1'b0;
        link.rx = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("midreset");
        rst_n = 1'b1;
        idle_bits(2);
        v0 = vcnt;
        send_word(32'h01020304, 0);
        check("midreset_valid", 32'(vcnt - v0), 32'd1);
        check("midreset_data", last_word, 32'h01020304);

        idle_bits(2);
        check("valid_ferr_overlap", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
